// File: rtl/alu_wb_sequencer.sv
// Purpose: sequences completed ALU operations into register-file and flag-register writebacks
//          (one beat for single-result ops, two beats for MUL/DIV that produce result_1).
// Latency: beat 0 one cycle after the accepting edge, beat 1 two cycles; in_ready drops for one cycle behind a dual op.
// Ports:   clk/reset_n; issue slot in_valid/in_ready + in_* fields; rf_we/rf_waddr/rf_wdata;
//          flag_we/flag_wdata; busy. All outputs are registered and zero while idle or in reset.
module alu_wb_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_alu_en,
    input  logic [4:0]  in_opcode,
    input  logic [2:0]  in_rd,
    input  logic        in_op2_zero,
    input  logic [15:0] in_result_0,
    input  logic [15:0] in_result_1,
    input  logic [15:0] in_flags,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        flag_we,
    output logic [15:0] flag_wdata,
    output logic        busy
);

    // Opcode encodings, kept identical to the ALU's parameters.v.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_MUL  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_NOT  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_CMP  = 5'd9;
    localparam logic [4:0] OP_RR   = 5'd10;
    localparam logic [4:0] OP_RL   = 5'd11;
    localparam logic [4:0] OP_SETB = 5'd12;
    localparam logic [4:0] OP_CLRB = 5'd13;
    localparam logic [4:0] OP_CPLB = 5'd14;
    localparam logic [4:0] OP_SETF = 5'd15;
    localparam logic [4:0] OP_CLRF = 5'd16;
    localparam logic [4:0] OP_CPLF = 5'd17;
    localparam logic [4:0] OP_LBL  = 5'd18;
    localparam logic [4:0] OP_LBH  = 5'd19;
    localparam logic [4:0] OP_MOV  = 5'd20;

    typedef enum logic [1:0] {S_IDLE, S_WB0, S_WB1} state_t;
    typedef enum logic [2:0] {C_NOP, C_SINGLE, C_DUAL, C_FLAG, C_MOVE} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d, in_cls;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] r1_q, r1_d;
    logic        accept;

    logic        in_ready_q, in_ready_d;
    logic        rf_we_q, rf_we_d;
    logic [2:0]  rf_waddr_q, rf_waddr_d;
    logic [15:0] rf_wdata_q, rf_wdata_d;
    logic        flag_we_q, flag_we_d;
    logic [15:0] flag_wdata_q, flag_wdata_d;
    logic        busy_q, busy_d;

    // Writeback class of the op currently in the issue slot.
    always_comb begin
        in_cls = C_NOP;
        case (in_opcode)
            OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC,
            OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB:
                in_cls = in_alu_en ? C_SINGLE : C_NOP;
            OP_MUL:
                in_cls = in_alu_en ? C_DUAL : C_NOP;
            // Divide by zero yields no result_1, so it collapses to one beat.
            OP_DIV:
                in_cls = in_alu_en ? (in_op2_zero ? C_SINGLE : C_DUAL) : C_NOP;
            OP_CMP, OP_SETF, OP_CLRF, OP_CPLF:
                in_cls = in_alu_en ? C_FLAG : C_NOP;
            OP_LBL, OP_LBH, OP_MOV:
                in_cls = in_alu_en ? C_NOP : C_MOVE;
            default:
                in_cls = C_NOP;
        endcase
    end

    always_comb begin
        accept  = in_valid && in_ready_q;
        state_d = state_q;
        cls_d   = cls_q;
        rd_d    = rd_q;
        r1_d    = r1_q;

        if (accept) begin
            cls_d = in_cls;
            rd_d  = in_rd;
            r1_d  = in_result_1;
        end

        case (state_q)
            S_IDLE:  state_d = accept ? S_WB0 : S_IDLE;
            S_WB0: begin
                if (cls_q == C_DUAL) state_d = S_WB1;
                else if (accept)     state_d = S_WB0;
                else                 state_d = S_IDLE;
            end
            S_WB1:   state_d = accept ? S_WB0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed for the state being entered so they line up with it.
        rf_we_d      = 1'b0;
        rf_waddr_d   = 3'd0;
        rf_wdata_d   = 16'd0;
        flag_we_d    = 1'b0;
        flag_wdata_d = 16'd0;

        if (state_d == S_WB0) begin
            // WB0 is only entered on an accept, so result_0/flags come straight from the slot.
            if (cls_d == C_SINGLE || cls_d == C_DUAL || cls_d == C_MOVE) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd_d;
                rf_wdata_d = in_result_0;
            end
            if (cls_d == C_SINGLE || cls_d == C_DUAL || cls_d == C_FLAG) begin
                flag_we_d    = 1'b1;
                flag_wdata_d = in_flags;
            end
        end else if (state_d == S_WB1) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q + 3'd1;   // wraps r7 -> r0
            rf_wdata_d = r1_q;
        end

        in_ready_d = !(state_d == S_WB0 && cls_d == C_DUAL);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cls_q        <= C_NOP;
            rd_q         <= 3'd0;
            r1_q         <= 16'd0;
            in_ready_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 3'd0;
            rf_wdata_q   <= 16'd0;
            flag_we_q    <= 1'b0;
            flag_wdata_q <= 16'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            rd_q         <= rd_d;
            r1_q         <= r1_d;
            in_ready_q   <= in_ready_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            flag_we_q    <= flag_we_d;
            flag_wdata_q <= flag_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign flag_we    = flag_we_q;
    assign flag_wdata = flag_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Purpose: scoreboard bench for alu_wb_sequencer; expected beats are queued at each accepting edge
//          and compared cycle by cycle on the falling edge.
// Covers reset values, single/dual/flag-only/move/NOP beats, stall behaviour, rd wrap and mid-beat reset.
module tb_alu_wb_sequencer;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_MUL  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_CMP  = 5'd9;
    localparam logic [4:0] OP_SETF = 5'd15;
    localparam logic [4:0] OP_CLRF = 5'd16;
    localparam logic [4:0] OP_CPLF = 5'd17;
    localparam logic [4:0] OP_LBL  = 5'd18;
    localparam logic [4:0] OP_LBH  = 5'd19;
    localparam logic [4:0] OP_MOV  = 5'd20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_alu_en;
    logic [4:0]  in_opcode;
    logic [2:0]  in_rd;
    logic        in_op2_zero;
    logic [15:0] in_result_0;
    logic [15:0] in_result_1;
    logic [15:0] in_flags;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_we;
    logic [15:0] flag_wdata;
    logic        busy;

    alu_wb_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_en   (in_alu_en),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_op2_zero (in_op2_zero),
        .in_result_0 (in_result_0),
        .in_result_1 (in_result_1),
        .in_flags    (in_flags),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .flag_we     (flag_we),
        .flag_wdata  (flag_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rf_we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        fwe;
        logic [15:0] fwd;
        logic        rdy;
    } beat_t;

    typedef struct {
        logic        alu_en;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic        z;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] fl;
    } op_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input bit en, input logic [4:0] op, input logic [2:0] rd, input bit z,
                               input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] fl);
        op_t o;
        o.alu_en = en; o.op = op; o.rd = rd; o.z = z; o.r0 = r0; o.r1 = r1; o.fl = fl;
        return o;
    endfunction

    // Reference model: expected writeback beats for one accepted op.
    task automatic push_exp(input op_t o);
        bit dual, flg, mov, single;
        beat_t b;
        dual   = o.alu_en && (o.op == OP_MUL || (o.op == OP_DIV && !o.z));
        flg    = o.alu_en && (o.op == OP_CMP || o.op == OP_SETF || o.op == OP_CLRF || o.op == OP_CPLF);
        mov    = !o.alu_en && (o.op == OP_LBL || o.op == OP_LBH || o.op == OP_MOV);
        single = o.alu_en && (o.op <= OP_CPLF) && !dual && !flg;
        b.rf_we = single || dual || mov;
        b.waddr = b.rf_we ? o.rd : 3'd0;
        b.wdata = b.rf_we ? o.r0 : 16'd0;
        b.fwe   = single || dual || flg;
        b.fwd   = b.fwe ? o.fl : 16'd0;
        b.rdy   = !dual;
        sb.push_back(b);
        if (dual) begin
            b.rf_we = 1'b1;
            b.waddr = o.rd + 3'd1;
            b.wdata = o.r1;
            b.fwe   = 1'b0;
            b.fwd   = 16'd0;
            b.rdy   = 1'b1;
            sb.push_back(b);
        end
    endtask

    // Present an op and hold it until accepted; expected beats are queued at the accepting edge.
    task automatic issue(input op_t o);
        int  waits;
        bit  acc;
        bit  done;
        waits = 0;
        done  = 1'b0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_alu_en   = o.alu_en;
        in_opcode   = o.op;
        in_rd       = o.rd;
        in_op2_zero = o.z;
        in_result_0 = o.r0;
        in_result_1 = o.r1;
        in_flags    = o.fl;
        while (!done) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                push_exp(o);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 8) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", o.op, waits);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    // Idle cycles with garbage on the fields, which must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid    = 1'b0;
            in_alu_en   = 1'($urandom);
            in_opcode   = 5'($urandom);
            in_rd       = 3'($urandom);
            in_op2_zero = 1'($urandom);
            in_result_0 = 16'($urandom);
            in_result_1 = 16'($urandom);
            in_flags    = 16'($urandom);
            @(posedge clk);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (mon_en) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                expect_eq("busy",       busy,       1);
                expect_eq("rf_we",      rf_we,      e.rf_we);
                expect_eq("rf_waddr",   rf_waddr,   e.waddr);
                expect_eq("rf_wdata",   rf_wdata,   e.wdata);
                expect_eq("flag_we",    flag_we,    e.fwe);
                expect_eq("flag_wdata", flag_wdata, e.fwd);
                expect_eq("in_ready",   in_ready,   e.rdy);
            end else begin
                expect_eq("idle_busy",       busy,       0);
                expect_eq("idle_rf_we",      rf_we,      0);
                expect_eq("idle_rf_waddr",   rf_waddr,   0);
                expect_eq("idle_rf_wdata",   rf_wdata,   0);
                expect_eq("idle_flag_we",    flag_we,    0);
                expect_eq("idle_flag_wdata", flag_wdata, 0);
                expect_eq("idle_in_ready",   in_ready,   1);
            end
        end
    end

    task automatic check_all_zero(input string pfx);
        expect_eq({pfx, "_rf_we"},      rf_we,      0);
        expect_eq({pfx, "_rf_waddr"},   rf_waddr,   0);
        expect_eq({pfx, "_rf_wdata"},   rf_wdata,   0);
        expect_eq({pfx, "_flag_we"},    flag_we,    0);
        expect_eq({pfx, "_flag_wdata"}, flag_wdata, 0);
        expect_eq({pfx, "_busy"},       busy,       0);
        expect_eq({pfx, "_in_ready"},   in_ready,   0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        op_t o;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_alu_en   = 1'b0;
        in_opcode   = 5'd0;
        in_rd       = 3'd0;
        in_op2_zero = 1'b0;
        in_result_0 = 16'd0;
        in_result_1 = 16'd0;
        in_flags    = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        expect_eq("rdy_before_first_edge", in_ready, 0);
        @(posedge clk);
        #1;
        expect_eq("rdy_after_first_edge", in_ready, 1);
        mon_en = 1'b1;
        idle(1);

        // Single-beat ADD, then idle
        issue(mk(1, OP_ADD, 3'd2, 0, 16'h0005, 16'h0000, 16'h0020));
        idle(2);
        // MUL to r7: second beat wraps to r0
        issue(mk(1, OP_MUL, 3'd7, 0, 16'h5678, 16'h1234, 16'h0004));
        idle(3);
        // Divide by zero: one beat only
        issue(mk(1, OP_DIV, 3'd3, 1, 16'hFFFF, 16'hBEEF, 16'h0080));
        idle(2);
        // Back-to-back flag-only, move, NOP
        issue(mk(1, OP_CMP, 3'd5, 0, 16'h1111, 16'h2222, 16'h0008));
        issue(mk(0, OP_MOV, 3'd1, 0, 16'h00AA, 16'h3333, 16'hFFFF));
        issue(mk(1, 5'd31,  3'd6, 0, 16'h4444, 16'h5555, 16'h6666));
        idle(2);
        // MUL followed immediately by ops held through the stall
        issue(mk(1, OP_MUL, 3'd4, 0, 16'hA0A0, 16'hB0B0, 16'h0001));
        issue(mk(1, OP_SUB, 3'd0, 0, 16'h0102, 16'h0304, 16'h0002));
        issue(mk(1, OP_DIV, 3'd7, 0, 16'h0007, 16'h0009, 16'h0010));
        issue(mk(1, OP_INC, 3'd6, 0, 16'h0042, 16'h0000, 16'h0000));
        issue(mk(0, OP_LBH, 3'd2, 0, 16'hCD00, 16'h0000, 16'h1234));
        issue(mk(0, OP_ADD, 3'd3, 0, 16'h9999, 16'h8888, 16'h7777));
        idle(2);

        for (int i = 0; i < 60; i++) begin
            o = mk(1'($urandom), 5'($urandom_range(0, 31)), 3'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) o.op = OP_MUL;
            issue(o);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // Reset during the WB0 beat of a MUL: the r(rd+1) beat must never appear
        issue(mk(1, OP_MUL, 3'd5, 0, 16'h1357, 16'h2468, 16'h0003));
        mon_en = 1'b0;
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        idle(3);
        // Still functional after the mid-beat reset
        issue(mk(1, OP_ADD, 3'd6, 0, 16'h0C0C, 16'h0000, 16'h0040));
        idle(2);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_wb_sequencer.md
ALU_WB_SEQUENCER -- requirements
Module: alu_wb_sequencer

Interface
REQ-001 The block SHALL have these parameters: none; opcode encodings (ADD, MUL, SUB, DIV, NOT, AND, OR, XOR, INC, CMP, RR, RL, SETB, CLRB, CPLB, SETF, CLRF, CPLF, LBL, LBH, MOV) come from parameters.v.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  issue slot holds a completed ALU operation.
REQ-005 in_ready  output  1  sequencer accepts the slot this cycle.
REQ-006 in_alu_en  input  1  alu_en the ALU used for this operation.
REQ-007 in_opcode  input  5  opcode of the operation.
REQ-008 in_rd  input  3  destination register.
REQ-009 in_op2_zero  input  1  operand_2 was zero (DIV by zero indicator).
REQ-010 in_result_0  input  16  ALU result_0.
REQ-011 in_result_1  input  16  ALU result_1.
REQ-012 in_flags  input  16  ALU next_flags.
REQ-013 rf_we  output  1  register-file write strobe.
REQ-014 rf_waddr  output  3  register-file write address.
REQ-015 rf_wdata  output  16  register-file write data.
REQ-016 flag_we  output  1  flag-register write enable (drives flag_reg_en).
REQ-017 flag_wdata  output  16  flag value to load.
REQ-018 busy  output  1  a writeback beat is in progress.

Function
REQ-019 The block SHALL accept an operation on a rising edge where in_valid and in_ready are both 1 (handshake); it SHALL capture all in_* fields at that edge.
REQ-020 The block SHALL classify the captured op as: DUAL = in_alu_en and (MUL, or DIV with in_op2_zero=0); FLAGONLY = in_alu_en and (CMP, SETF, CLRF, CPLF); MOVE = !in_alu_en and (LBL, LBH, MOV); SINGLE = in_alu_en and any other defined ALU opcode, including DIV with in_op2_zero=1; NOP = anything else.
REQ-021 The block SHALL implement states IDLE, WB0, WB1; accept moves to WB0; WB0 moves to WB1 if DUAL, else to WB0 on a new accept, else to IDLE; WB1 moves to WB0 on a new accept, else to IDLE.
REQ-022 The block SHALL register all outputs so that a beat's outputs are valid exactly in the state cycle; latency is 1 cycle for beat 0 and 2 cycles for beat 1 after the accepting edge.
REQ-023 In WB0, rf_we SHALL be 1 for SINGLE, DUAL and MOVE, with rf_waddr=rd and rf_wdata=result_0; rf_we SHALL be 0 for FLAGONLY and NOP.
REQ-024 In WB0, flag_we SHALL be 1 with flag_wdata=flags for SINGLE, DUAL and FLAGONLY, and 0 for MOVE and NOP.
REQ-025 In WB1, the block SHALL drive rf_we=1, rf_waddr=(rd+1) mod 8 (rd=7 wraps to 0), rf_wdata=result_1, and flag_we=0.
REQ-026 in_ready SHALL be 1 in IDLE and WB1, 1 in WB0 for non-DUAL ops, and 0 in WB0 for DUAL ops (one-cycle stall); sustained throughput is 1 op/cycle for non-DUAL ops.
REQ-027 busy SHALL be 1 in WB0 and WB1 and 0 in IDLE.
REQ-028 When rf_we=0 or flag_we=0, the block SHALL hold rf_waddr/rf_wdata/flag_wdata at 0.
REQ-029 The block SHALL ignore in_* fields when in_valid=0 or in_ready=0; the issuer holds them stable until accepted.
REQ-030 A NOP SHALL still occupy one WB0 cycle and write nothing.

Reset
REQ-031 While reset_n=0, the block SHALL force state IDLE and rf_we=0, rf_waddr=0, rf_wdata=0, flag_we=0, flag_wdata=0, busy=0, and in_ready=0; in_ready SHALL go to 1 on the first clk edge after reset_n rises.
REQ-032 A reset_n assertion during WB0 or WB1 SHALL drop that beat immediately; the pending result_1 is lost and is not written after reset.

Verification
REQ-033 ADD, rd=2, result_0=16'h0005, flags=16'h0020 accepted at edge N -> cycle N+1: rf_we=1, waddr=2, wdata=0005, flag_we=1, flag_wdata=0020; cycle N+2: IDLE, busy=0.
REQ-034 MUL, rd=7, result_0=16'h5678, result_1=16'h1234 -> N+1: write r7=5678 with flag_we=1, in_ready=0; N+2: write r0=1234 with flag_we=0, in_ready=1.
REQ-035 DIV with in_op2_zero=1, rd=3, result_0=FFFF -> single beat writing r3=FFFF with flag_we=1; no second write.
REQ-036 Back-to-back CMP (flags=0008), then MOV (rd=1, result_0=00AA), then NOP -> three consecutive WB0 cycles: flag-only write, then register-only write r1=00AA, then no writes; in_ready stays 1 throughout.
REQ-037 Reset_n pulled low in the WB0 cycle of a MUL -> all outputs go to 0 asynchronously and no write to rd+1 occurs after release.
REQ-038 MUL held with in_valid=1 while in_ready=0 with its fields unchanged -> the MUL is accepted exactly once.
